ifetch_queue: RTL and testbench
===============================

// Module: ifetch_queue
// PURPOSE
//   Instruction fetch stage that sits directly upstream of the processor's decode/execute stage.
//   Owns the fetch PC and drives the word address of the combinational-read instruction memory.
//   Buffers {pc, instruction} pairs in a small FIFO; decode consumes them with a valid/ready handshake.
//   A branch redirect from execute flushes the queue and restarts fetch at the target.
// PARAMETERS
//   DEPTH     4         queue entries; power of two, >= 2
//   RESET_PC  32'h0     fetch PC loaded on reset; bits [1:0] must be 0
//   ADDR_W    11        instruction-memory word-address width (2048 words)
// PORTS
//   w_clk          in   1       clock, all state on rising edge
//   w_rst_n        in   1       reset, asynchronous assert, active-low
//   w_imem_addr    out  ADDR_W  word address to instruction memory = r_pc[ADDR_W+1:2]
//   w_imem_data    in   32      instruction word at w_imem_addr, valid in the same cycle
//   w_redirect     in   1       execute took a branch: flush and refetch
//   w_redirect_pc  in   32      branch target; bits [1:0] ignored, treated as 0
//   w_ir           out  32      instruction at queue head; 0 when w_ir_valid=0
//   w_ir_pc        out  32      PC of w_ir; 0 when w_ir_valid=0
//   w_ir_valid     out  1       queue non-empty
//   w_ir_ready     in   1       decode accepts head this cycle
//   w_fetch_pc     out  32      current fetch PC (r_pc)
//   w_halted       out  1       fetch stopped on HALT word (see CONFIGURATION)
// BEHAVIOUR
//   Reset (async, w_rst_n=0): r_pc=RESET_PC, queue empty, count=0, halted=0; w_ir=0, w_ir_pc=0, w_ir_valid=0.
//   pop  = w_ir_valid & w_ir_ready.
//   push = !w_redirect & !halted & (count<DEPTH | pop); writes {r_pc, w_imem_data}; r_pc <= r_pc+4.
//   Full with pop in the same cycle: push allowed, count unchanged. Full without pop: no push, r_pc holds.
//   Simultaneous push and pop: count unchanged. Empty: pop impossible (valid=0).
//   Redirect has priority over everything: r_pc <= {w_redirect_pc[31:2],2'b00}; rd/wr pointers and count cleared;
//   no push that cycle; a pop that coincides with redirect counts as consumed by decode; halted cleared.
//   Latency: word at r_pc visible at w_ir one cycle after the push edge; after reset release, the first
//   instruction is valid after the first rising edge; after redirect, the target is valid after the following edge.
//   Wrap-around: r_pc wraps modulo 2^32; w_imem_addr wraps modulo 2^ADDR_W words; pointers wrap modulo DEPTH.
//   Count width = log2(DEPTH)+1; never exceeds DEPTH.
//   Reset asserted mid-operation: immediate clear to the reset state; in-flight entries are discarded.
// CONFIGURATION
//   FETCH_HALT_STOP_EN defined: a pushed word equal to HALT_WORD (32'h00000011) sets halted in the same edge.
//     Following cycles: no push, r_pc frozen at HALT addr+4, w_halted=1. Queued entries, including the HALT
//     itself, still drain to decode. Cleared only by redirect or reset.
//   Not defined: HALT word is fetched like any other word; halted logic absent; w_halted tied 0.
// STRUCTURE
//   Package ifetch_pkg: HALT_WORD constant; PC_W=32; typedef fetch_entry_t {pc[31:0], ir[31:0]}.
//   Sub-module fetch_fifo: synchronous FIFO of fetch_entry_t, DEPTH param, push/pop/flush, count/empty/full.
//   Top holds r_pc, halted flag, push/pop/redirect control, output masking.
// TESTING
//   1 Reset, mem[k]=32'h1000+k, ready=1 -> w_ir_pc 0,4,8,... each cycle from first edge, w_ir 1000,1001,...
//   2 ready=0 for 10 cycles -> exactly DEPTH=4 entries held, w_fetch_pc=16, w_ir_pc stays 0;
//     ready=1 -> pcs 0,4,8,12,16 in order, none lost or duplicated.
//   3 Full with ready=1 steady -> one push and one pop per cycle, count stays 4.
//   4 Redirect to 32'h0000_0103 while 3 entries queued -> next cycle w_ir_valid=0; the cycle after,
//     w_ir_pc=32'h100 and w_imem_addr=11'h40 in the redirect-following cycle.
//   5 Reset pulse w_rst_n=0 mid-stream, asynchronous to the clock -> outputs 0 and valid=0 before the next
//     edge; restart at RESET_PC.
//   6 FETCH_HALT_STOP_EN, mem[3]=32'h11 -> entries pc 0..12 delivered, w_halted=1, w_fetch_pc=16 frozen;
//     redirect to 0 -> halted=0 and fetch resumes.

Source files
------------

// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch queue.
// The HALT_WORD constant is only used when FETCH_HALT_STOP_EN is defined.
package ifetch_pkg;

    localparam int          PC_W      = 32;
    localparam logic [31:0] HALT_WORD = 32'h0000_0011;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [31:0]     ir;
    } fetch_entry_t;

endpackage : ifetch_pkg

// File: rtl/ifetch_queue_fetch_fifo.sv
// Small synchronous FIFO of {pc, instruction} entries with flush.
// The head entry is read combinationally so a push is visible one cycle later.
module fetch_fifo
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    input  fetch_entry_t           wdata_i,
    output fetch_entry_t           rdata_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   empty_o,
    output logic                   full_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    fetch_entry_t entry_q [DEPTH];

    assign do_push = push_i & ~flush_i;
    assign do_pop  = pop_i & ~flush_i & (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage carries no reset: stale contents are masked by the count.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk_i) begin
            if (do_push && (wr_ptr_q == PTR_W'(gi))) begin
                entry_q[gi] <= wdata_i;
            end
        end
    end

    assign rdata_o = entry_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));

endmodule : fetch_fifo

// File: rtl/ifetch_queue.sv
// Instruction fetch stage: owns the fetch PC, buffers fetched words for decode.
// Define FETCH_HALT_STOP_EN to stop fetching after a HALT word has been pushed.
module ifetch_queue
    import ifetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int          ADDR_W   = 11
) (
    input  logic              w_clk,
    input  logic              w_rst_n,
    output logic [ADDR_W-1:0] w_imem_addr,
    input  logic [31:0]       w_imem_data,
    input  logic              w_redirect,
    input  logic [31:0]       w_redirect_pc,
    output logic [31:0]       w_ir,
    output logic [31:0]       w_ir_pc,
    output logic              w_ir_valid,
    input  logic              w_ir_ready,
    output logic [31:0]       w_fetch_pc,
    output logic              w_halted
);

    logic [PC_W-1:0]        pc_q, pc_d;
    logic                   push;
    logic                   pop;
    logic                   fifo_empty;
    logic                   fifo_full;
    logic                   halted;
    fetch_entry_t           push_entry;
    fetch_entry_t           head_entry;
    logic [$clog2(DEPTH):0] unused_count;
    logic                   unused_redirect_bits;

    assign unused_redirect_bits = ^w_redirect_pc[1:0];

    assign pop = ~fifo_empty & w_ir_ready;

    // A full queue still accepts a word when the head leaves in the same cycle.
    assign push = ~w_redirect & ~halted & (~fifo_full | pop);

    assign push_entry.pc = pc_q;
    assign push_entry.ir = w_imem_data;

    always_comb begin
        pc_d = pc_q;
        if (w_redirect) begin
            pc_d = {w_redirect_pc[31:2], 2'b00};
        end else if (push) begin
            pc_d = pc_q + 32'd4;
        end
    end

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

`ifdef FETCH_HALT_STOP_EN
    logic halted_q, halted_d;

    always_comb begin
        halted_d = halted_q;
        if (w_redirect) begin
            halted_d = 1'b0;
        end else if (push && (w_imem_data == HALT_WORD)) begin
            halted_d = 1'b1;
        end
    end

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            halted_q <= 1'b0;
        end else begin
            halted_q <= halted_d;
        end
    end

    assign halted = halted_q;
`else
    assign halted = 1'b0;
`endif

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (w_clk),
        .rst_ni  (w_rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (w_redirect),
        .wdata_i (push_entry),
        .rdata_o (head_entry),
        .count_o (unused_count),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    assign w_imem_addr = pc_q[ADDR_W+1:2];
    assign w_fetch_pc  = pc_q;
    assign w_halted    = halted;
    assign w_ir_valid  = ~fifo_empty;
    assign w_ir        = fifo_empty ? 32'h0 : head_entry.ir;
    assign w_ir_pc     = fifo_empty ? 32'h0 : head_entry.pc;

endmodule : ifetch_queue

// File: tb/tb_ifetch_queue.sv
// Randomized bench for ifetch_queue against a queue-based reference model.
// Builds with or without FETCH_HALT_STOP_EN; the model follows the same define.
module tb_ifetch_queue;

    localparam int          DEPTH    = 4;
    localparam int          ADDR_W   = 11;
    localparam logic [31:0] RESET_PC = 32'h0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ir;
    } ent_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_data;
    logic              redirect;
    logic [31:0]       redirect_pc;
    logic [31:0]       ir;
    logic [31:0]       ir_pc;
    logic              ir_valid;
    logic              ir_ready;
    logic [31:0]       fetch_pc;
    logic              halted;

    logic [31:0] mem [0:(1<<ADDR_W)-1];

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_pc;
    bit          m_halted;
    ent_t        mq[$];

    always #5 clk = ~clk;

    assign imem_data = mem[imem_addr];

    ifetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC),
        .ADDR_W   (ADDR_W)
    ) dut (
        .w_clk         (clk),
        .w_rst_n       (rst_n),
        .w_imem_addr   (imem_addr),
        .w_imem_data   (imem_data),
        .w_redirect    (redirect),
        .w_redirect_pc (redirect_pc),
        .w_ir          (ir),
        .w_ir_pc       (ir_pc),
        .w_ir_valid    (ir_valid),
        .w_ir_ready    (ir_ready),
        .w_fetch_pc    (fetch_pc),
        .w_halted      (halted)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc     = RESET_PC;
        m_halted = 1'b0;
        mq.delete();
    endtask

    // Applies one rising edge to the model using the inputs present before it.
    task automatic model_edge();
        int   sz;
        bit   pop;
        ent_t e;
        if (!rst_n) begin
            model_reset();
            return;
        end
        sz  = mq.size();
        pop = (sz > 0) && ir_ready;
        if (redirect) begin
            mq.delete();
            m_pc     = redirect_pc & 32'hFFFF_FFFC;
            m_halted = 1'b0;
        end else begin
            if (pop) void'(mq.pop_front());
            if (!m_halted && (sz < DEPTH || pop)) begin
                e.pc = m_pc;
                e.ir = mem[(m_pc / 4) % (1 << ADDR_W)];
                mq.push_back(e);
`ifdef FETCH_HALT_STOP_EN
                if (e.ir == 32'h0000_0011) m_halted = 1'b1;
`endif
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic check_outputs();
        bit v;
        v = (mq.size() > 0);
        check_eq("ir_valid", {31'b0, ir_valid}, {31'b0, v});
        check_eq("ir", ir, v ? mq[0].ir : 32'h0);
        check_eq("ir_pc", ir_pc, v ? mq[0].pc : 32'h0);
        check_eq("fetch_pc", fetch_pc, m_pc);
        check_eq("imem_addr", {21'b0, imem_addr}, (m_pc / 4) % (1 << ADDR_W));
        check_eq("halted", {31'b0, halted}, {31'b0, m_halted});
    endtask

    // One transaction: drive inputs, check before the edge, advance the model.
    task automatic cycle(input bit rdy, input bit redir, input logic [31:0] rpc);
        ir_ready    = rdy;
        redirect    = redir;
        redirect_pc = rpc;
        @(negedge clk);
        check_outputs();
        $display("cyc t=%0t rdy=%0d redir=%0d valid=%0d ir_pc=%h ir=%h fpc=%h",
                 $time, rdy, redir, ir_valid, ir_pc, ir, fetch_pc);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        ir_ready    = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        @(posedge clk);
        @(posedge clk);
        model_reset();
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        for (int k = 0; k < (1 << ADDR_W); k++) mem[k] = 32'h1000 + k;

        // Reset state and streaming with decode always ready
        do_reset();
        check_eq("rst_valid", {31'b0, ir_valid}, 32'h0);
        check_eq("rst_fetch_pc", fetch_pc, RESET_PC);
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 32'h0);

        // Stall fills the queue to DEPTH, then drains in order
        do_reset();
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 32'h0);
        check_eq("full_fetch_pc", fetch_pc, 32'd16);
        check_eq("full_head_pc", ir_pc, 32'd0);
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 32'h0);

        // Redirect with three entries queued
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 32'h0000_0103);
        check_eq("redir_valid", {31'b0, ir_valid}, 32'h0);
        check_eq("redir_addr", {21'b0, imem_addr}, 32'h40);
        cycle(1'b1, 1'b0, 32'h0);
        check_eq("redir_head_pc", ir_pc, 32'h100);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 32'h0);

        // Asynchronous reset between edges clears outputs immediately
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_valid", {31'b0, ir_valid}, 32'h0);
        check_eq("async_ir", ir, 32'h0);
        check_eq("async_ir_pc", ir_pc, 32'h0);
        check_eq("async_fetch_pc", fetch_pc, RESET_PC);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 32'h0);

        // HALT word at address 12, then redirect back to 0
        mem[3] = 32'h0000_0011;
        do_reset();
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 32'h0);
`ifdef FETCH_HALT_STOP_EN
        check_eq("halt_flag", {31'b0, halted}, 32'h1);
        check_eq("halt_fetch_pc", fetch_pc, 32'd16);
`endif
        cycle(1'b1, 1'b1, 32'h0);
        check_eq("halt_cleared", {31'b0, halted}, 32'h0);
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 32'h0);
        mem[3] = 32'h1003;

        // Randomized traffic including redirects near the top of the address space
        for (int i = 0; i < 3000; i++) begin
            bit          rdy;
            bit          rd;
            logic [31:0] tgt;
            rdy = ($urandom_range(0, 3) != 0);
            rd  = ($urandom_range(0, 19) == 0);
            tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFE0 | ($urandom & 32'h1F))
                                              : ($urandom & 32'h3FFF);
            if ($urandom_range(0, 7) == 0) mem[$urandom_range(0, 15)] = 32'h0000_0011;
            cycle(rdy, rd, tgt);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_ifetch_queue
